fir_tap_sequencer: RTL

- Time-multiplexed FIR controller that runs an `N_TAPS`-tap unsigned filter through one shared `BW_in`×`BW_in` multiplier.
- After reset it loads `N_TAPS` coefficients serially through the sample port, then accepts one sample per handshake.
- For each sample it sequences the multiplier over all taps, accumulates the products, and presents a registered output with valid/ready.
- It sits between the pin-level input bus and the output pins, replacing the single-coefficient direct multiply.

---
 rtl/fir_tap_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fir_tap_sequencer.sv
// ============================================================================
// Module   : fir_tap_sequencer
// Purpose  : Time-multiplexed N_TAPS unsigned FIR using one shared multiplier.
//            Coefficients are loaded serially after reset, then one sample per
//            handshake is filtered. Optional macro: FIR_SATURATE_EN (saturate
//            y_out instead of truncating).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_tap_sequencer #(
    parameter int N_TAPS     = 4,
    parameter int BW_in      = 6,
    parameter int BW_product = 12,
    parameter int BW_acc     = BW_product + $clog2(N_TAPS),
    parameter int BW_out     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BW_in-1:0]  x_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BW_out-1:0] y_out,
    output logic              coef_loaded,
    output logic              busy
);

    localparam int c_cnt_w = $clog2(N_TAPS);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(N_TAPS - 1);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_IDLE = 2'd1,
        S_MAC  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t             r_state;
    logic [BW_in-1:0]   r_coef [N_TAPS];
    logic [BW_in-1:0]   r_hist [N_TAPS];
    logic [BW_acc-1:0]  r_acc;
    logic [c_cnt_w-1:0] r_k;
    logic [c_cnt_w-1:0] r_cnt;

    logic [BW_product-1:0] w_prod;
    logic [BW_acc-1:0]     w_sum;
    logic [BW_out-1:0]     w_y;

    assign w_prod = BW_product'(r_coef[r_k]) * BW_product'(r_hist[r_k]);
    assign w_sum  = r_acc + BW_acc'(w_prod);

`ifdef FIR_SATURATE_EN
    localparam logic [BW_acc-1:0] c_out_max = BW_acc'({BW_out{1'b1}});
    assign w_y = (w_sum > c_out_max) ? {BW_out{1'b1}} : w_sum[BW_out-1:0];
`else
    assign w_y = w_sum[BW_out-1:0];
`endif

    assign in_ready = ((r_state == S_LOAD) || (r_state == S_IDLE)) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_LOAD;
            r_acc       <= '0;
            r_k         <= '0;
            r_cnt       <= '0;
            out_valid   <= 1'b0;
            y_out       <= '0;
            coef_loaded <= 1'b0;
            busy        <= 1'b0;
            for (int i = 0; i < N_TAPS; i++) begin
                r_coef[i] <= '0;
                r_hist[i] <= '0;
            end
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (in_valid) begin
                        r_coef[r_cnt] <= x_in;
                        r_cnt         <= r_cnt + c_cnt_w'(1);
                        if (r_cnt == c_last) begin
                            coef_loaded <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                S_IDLE: begin
                    if (in_valid) begin
                        r_hist[0] <= x_in;
                        for (int i = 1; i < N_TAPS; i++) begin
                            r_hist[i] <= r_hist[i-1];
                        end
                        r_acc   <= '0;
                        r_k     <= '0;
                        busy    <= 1'b1;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= w_sum;
                    r_k   <= r_k + c_cnt_w'(1);
                    // Last tap: capture the complete sum straight from the adder.
                    if (r_k == c_last) begin
                        y_out     <= w_y;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

endmodule

`default_nettype wire
